sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Two-port arbiter that shares the single SDRAM controller between the video framebuffer fetch (port 0, high priority) and the renderer write/read path (port 1). It latches one command at a time and drives it onto the controller's active-low read/write enables until the controller accepts it. Reads are pipelined, and returned read data is routed back to the originating port in issue order through an internal tag FIFO. It sits between the requesters and the sdram controller instance, in the MAIN_CLK domain.

Parameters:
ADDR_W, 25, SDRAM word address width
DATA_W, 16, SDRAM data width
MAX_RD, 4, maximum reads granted but not yet returned (tag FIFO depth), power of two
STARVE_LIMIT, 8, consecutive port-0 grants allowed while port 1 is requesting

Ports:
CLK  in  1  MAIN_CLK domain clock
RESET_N  in  1  asynchronous active-low reset
REQ0, REQ1  in  1 each  request valid; held until GNTx
WE0, WE1  in  1 each  1 = write, 0 = read
ADDR0, ADDR1  in  ADDR_W each  word address
WDATA0, WDATA1  in  DATA_W each  write data
GNT0, GNT1  out  1 each  one-cycle pulse: request consumed
RDATA  out  DATA_W  returned read data (shared)
RVALID0, RVALID1  out  1 each  RDATA valid for that port
SD_ADDR  out  ADDR_W  to controller address
SD_WDATA  out  DATA_W  to controller write data
SD_RD_N, SD_WR_N  out  1 each  active-low read/write enable to controller
SD_WAITREQ  in  1  high = controller not accepting the command this cycle
SD_RDATA  in  DATA_W  controller read data
SD_RDVALID  in  1  SD_RDATA valid
OUTSTANDING  out  clog2(MAX_RD+1)  reads granted, not yet returned
ERR  out  1  sticky: read data returned with no pending tag

Behaviour:
- Reset (RESET_N low, asynchronous): SD_RD_N=1, SD_WR_N=1, SD_ADDR=0, SD_WDATA=0, GNT0/1=0, RVALID0/1=0, RDATA=0, OUTSTANDING=0, ERR=0, tag FIFO empty, starvation counter 0, state IDLE. Reset mid-command drops the command. Reads in flight at reset are lost.
- States: IDLE and ISSUE.
- IDLE: select a requester and latch its ADDR/WDATA/WE into SD_ADDR/SD_WDATA/command register. Pulse GNTx for that cycle. Next state is ISSUE.
  - Eligibility: a read request is eligible only if OUTSTANDING < MAX_RD. A write request is always eligible.
  - Selection: port 0 wins unless the starvation counter has reached STARVE_LIMIT and REQ1 is eligible. In that case port 1 wins and the counter clears.
  - Starvation counter: increments on a port-0 grant while REQ1 is high. It clears on a port-1 grant, or on a port-0 grant while REQ1 is low.
  - On a read grant: push the port id into the tag FIFO and increment OUTSTANDING.
- ISSUE: drive SD_RD_N=0 or SD_WR_N=0 per the latched WE. Address and data are held stable.
  - At a clock edge where SD_WAITREQ=0, the command is accepted.
  - On acceptance, if an eligible request exists, the grant/latch happens in the same cycle and the block stays in ISSUE (back-to-back, one command per cycle). Otherwise it deasserts the enable and returns to IDLE.
  - SD_WAITREQ=1 holds the state with no timeout.
- Enables: SD_RD_N and SD_WR_N are registered outputs. They are never both low.
- Read return: on SD_RDVALID, pop the FIFO head and decrement OUTSTANDING. One cycle later, RDATA=SD_RDATA and RVALIDp=1 for the popped port; pulse width is 1 cycle per word.
  - A read grant and an SD_RDVALID in the same cycle leave OUTSTANDING unchanged. FIFO push and pop are both performed.
  - SD_RDVALID with an empty FIFO: data is discarded, no RVALID, and ERR sets and stays set until reset.
- Write latency: GNT at cycle N, and the enable is low from N+1 until accepted. Minimum read latency from grant is 2 cycles plus controller latency.

Test Plan:
- Single write, port 1: ADDR1=0x00010, WDATA1=0x0025, WAITREQ tied 0 -> GNT1 pulses cycle N; SD_WR_N=0 with SD_ADDR=0x00010, SD_WDATA=0x0025 in cycle N+1 only.
- Waitrequest stall: port 0 read of 0x1234 with WAITREQ high for 3 cycles -> SD_RD_N stays low for 4 cycles with SD_ADDR stable at 0x1234; OUTSTANDING=1 from N+1.
- Read routing: port 0 reads A, then port 1 reads B; controller returns 0xAAAA then 0xBBBB -> RVALID0 with RDATA=0xAAAA, then RVALID1 with RDATA=0xBBBB; OUTSTANDING returns to 0.
- Outstanding limit: port 1 issues 5 reads with no RDVALID -> only 4 GNT1; the 5th is granted in the cycle after the first RDVALID; a port-0 write is granted while reads are blocked.
- Starvation: REQ0 and REQ1 held high continuously, STARVE_LIMIT=8 -> grant sequence is eight port-0 grants then one port-1 grant, repeating.
- Error and reset: SD_RDVALID with OUTSTANDING=0 -> ERR=1, no RVALID. RESET_N low mid-ISSUE -> SD_RD_N=SD_WR_N=1 and ERR=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between the framebuffer fetch
// (port 0, high priority) and the renderer (port 1). One command is latched
// at a time and presented on the active-low enables until accepted. Read
// returns are routed back to their originating port through a tag FIFO.
//
// Handshake: REQx is held until GNTx. GNTx is a combinational one-cycle
// pulse in the cycle the request is consumed. The controller accepts the
// presented command at any clock edge where SD_WAITREQ is low. Return data
// is qualified by SD_RDVALID and handed back one cycle later on RVALIDx.
module sdram_arbiter #(
   parameter int ADDR_W       = 25,
   parameter int DATA_W       = 16,
   parameter int MAX_RD       = 4,
   parameter int STARVE_LIMIT = 8,
   localparam int OUT_W       = $clog2(MAX_RD + 1)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WE0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA0,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              GNT0,
   output logic              GNT1,
   output logic [DATA_W-1:0] RDATA,
   output logic              RVALID0,
   output logic              RVALID1,
   output logic [ADDR_W-1:0] SD_ADDR,
   output logic [DATA_W-1:0] SD_WDATA,
   output logic              SD_RD_N,
   output logic              SD_WR_N,
   input  logic              SD_WAITREQ,
   input  logic [DATA_W-1:0] SD_RDATA,
   input  logic              SD_RDVALID,
   output logic [OUT_W-1:0]  OUTSTANDING,
   output logic              ERR,
   output logic              DBG_STATE
);

   localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   starve_cnt;
   logic               tag_mem [MAX_RD];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;

   logic rd_ok, elig0, elig1, starved, slot_free;
   logic grant0, grant1, any_grant, sel_we;
   logic push, pop;

   assign rd_ok     = (OUTSTANDING < OUT_W'(MAX_RD));
   assign elig0     = REQ0 && (WE0 || rd_ok);
   assign elig1     = REQ1 && (WE1 || rd_ok);
   assign starved   = (starve_cnt >= CNT_W'(STARVE_LIMIT));
   // A new command can be latched when nothing is presented, or when the
   // presented command is being accepted at this edge.
   assign slot_free = (state == IDLE) || !SD_WAITREQ;
   assign any_grant = grant0 || grant1;
   assign sel_we    = grant1 ? WE1 : WE0;
   assign push      = (grant0 && !WE0) || (grant1 && !WE1);
   assign pop       = SD_RDVALID && (OUTSTANDING != '0);

   assign GNT0      = grant0;
   assign GNT1      = grant1;
   assign DBG_STATE = state;

   // Arbitration and next-state: port 0 wins unless port 1 has been starved.
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (RESET_N && slot_free) begin
         if (elig1 && (!elig0 || starved)) grant1 = 1'b1;
         else if (elig0)                   grant0 = 1'b1;
      end
      case (state)
         IDLE:    if (any_grant) state_nxt = ISSUE;
         ISSUE:   if (!SD_WAITREQ && !any_grant) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   // Command register: latch on grant, release the enable on a bare accept.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         SD_ADDR  <= '0;
         SD_WDATA <= '0;
         SD_RD_N  <= 1'b1;
         SD_WR_N  <= 1'b1;
      end else if (any_grant) begin
         SD_ADDR  <= grant1 ? ADDR1 : ADDR0;
         SD_WDATA <= grant1 ? WDATA1 : WDATA0;
         SD_RD_N  <= sel_we;
         SD_WR_N  <= !sel_we;
      end else if (state == ISSUE && !SD_WAITREQ) begin
         SD_RD_N  <= 1'b1;
         SD_WR_N  <= 1'b1;
      end
   end

   // Starvation counter: counts port-0 wins while port 1 is waiting.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) starve_cnt <= '0;
      else if (grant0) begin
         if (!REQ1)        starve_cnt <= '0;
         else if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (grant1) starve_cnt <= '0;
   end

   // Tag storage holds the issuing port of each read, in grant order.
   always_ff @(posedge CLK) begin
      if (push) tag_mem[wr_ptr] <= grant1;
   end

   // Tag FIFO pointers and the outstanding-read count.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         OUTSTANDING <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(MAX_RD - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(MAX_RD - 1)) ? '0 : rd_ptr + PTR_W'(1);
         OUTSTANDING <= OUTSTANDING + OUT_W'(push) - OUT_W'(pop);
      end
   end

   // Read return: route data to the tagged port; untagged data flags ERR.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         RDATA   <= '0;
         RVALID0 <= 1'b0;
         RVALID1 <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         RVALID0 <= pop && !tag_mem[rd_ptr];
         RVALID1 <= pop && tag_mem[rd_ptr];
         if (pop) RDATA <= SD_RDATA;
         if (SD_RDVALID && (OUTSTANDING == '0)) ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed steps followed by a randomized phase in which
// the bench plays both requesters and the SDRAM controller, and predicts
// command order, outstanding reads and read routing from queues.
module tb_sdram_arbiter;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 16;
   localparam int MAX_RD = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int OUT_W = $clog2(MAX_RD + 1);
   localparam int CW = 2 + ADDR_W + DATA_W;

   logic              CLK, RESET_N;
   logic              REQ0, REQ1, WE0, WE1;
   logic [ADDR_W-1:0] ADDR0, ADDR1;
   logic [DATA_W-1:0] WDATA0, WDATA1;
   logic              GNT0, GNT1;
   logic [DATA_W-1:0] RDATA;
   logic              RVALID0, RVALID1;
   logic [ADDR_W-1:0] SD_ADDR;
   logic [DATA_W-1:0] SD_WDATA;
   logic              SD_RD_N, SD_WR_N, SD_WAITREQ, SD_RDVALID;
   logic [DATA_W-1:0] SD_RDATA;
   logic [OUT_W-1:0]  OUTSTANDING;
   logic              ERR, DBG_STATE;

   int n_assert = 0;
   int n_fail   = 0;

   // scoreboard state
   logic [CW-1:0]     cmd_q[$];      // {port, we, addr, wdata} in grant order
   logic              rd_port_q[$];  // accepted reads awaiting return
   logic [DATA_W:0]   exp_q[$];      // {port, data} expected on RVALID next cycle
   int                model_out;

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD),
                   .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA),
      .RVALID0(RVALID0), .RVALID1(RVALID1),
      .SD_ADDR(SD_ADDR), .SD_WDATA(SD_WDATA),
      .SD_RD_N(SD_RD_N), .SD_WR_N(SD_WR_N), .SD_WAITREQ(SD_WAITREQ),
      .SD_RDATA(SD_RDATA), .SD_RDVALID(SD_RDVALID),
      .OUTSTANDING(OUTSTANDING), .ERR(ERR), .DBG_STATE(DBG_STATE)
   );

   // clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // let combinational outputs settle after driving inputs
   task automatic settle();
      #1;
   endtask

   initial begin
      int g1;
      logic [CW-1:0]     c_exp;
      logic [DATA_W:0]   e;
      logic              p, ret, g0s, g1s;
      logic [DATA_W-1:0] d;

      RESET_N = 1'b0;
      REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
      ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
      SD_WAITREQ = 0; SD_RDVALID = 0; SD_RDATA = '0;

      // ---- reset values ----
      #12;
      chk("rst_rd_n", 32'(SD_RD_N), 1);
      chk("rst_wr_n", 32'(SD_WR_N), 1);
      chk("rst_addr", 32'(SD_ADDR), 0);
      chk("rst_wdata", 32'(SD_WDATA), 0);
      chk("rst_gnt", 32'({GNT0, GNT1}), 0);
      chk("rst_rvalid", 32'({RVALID0, RVALID1}), 0);
      chk("rst_rdata", 32'(RDATA), 0);
      chk("rst_outstanding", 32'(OUTSTANDING), 0);
      chk("rst_err", 32'(ERR), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      cyc();

      // ---- single write, port 1 ----
      REQ1 = 1; WE1 = 1; ADDR1 = 25'h00010; WDATA1 = 16'h0025;
      settle();
      chk("w1_gnt1", 32'(GNT1), 1);
      chk("w1_gnt0", 32'(GNT0), 0);
      chk("w1_wr_n_before", 32'(SD_WR_N), 1);
      cyc(); REQ1 = 0; settle();
      chk("w1_wr_n", 32'(SD_WR_N), 0);
      chk("w1_rd_n", 32'(SD_RD_N), 1);
      chk("w1_addr", 32'(SD_ADDR), 32'h10);
      chk("w1_wdata", 32'(SD_WDATA), 32'h25);
      chk("w1_gnt1_pulse", 32'(GNT1), 0);
      cyc(); settle();
      chk("w1_wr_n_after", 32'(SD_WR_N), 1);

      // ---- waitrequest stall, port 0 read ----
      REQ0 = 1; WE0 = 0; ADDR0 = 25'h1234;
      settle();
      chk("st_gnt0", 32'(GNT0), 1);
      cyc(); REQ0 = 0; SD_WAITREQ = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("st_rd_n_wait", 32'(SD_RD_N), 0);
         chk("st_addr_wait", 32'(SD_ADDR), 32'h1234);
         chk("st_outstanding", 32'(OUTSTANDING), 1);
         cyc();
      end
      SD_WAITREQ = 0; settle();
      chk("st_rd_n_accept", 32'(SD_RD_N), 0);
      chk("st_addr_accept", 32'(SD_ADDR), 32'h1234);
      cyc(); settle();
      chk("st_rd_n_release", 32'(SD_RD_N), 1);
      SD_RDVALID = 1; SD_RDATA = 16'h5A5A;
      cyc(); SD_RDVALID = 0; settle();
      chk("st_rvalid0", 32'(RVALID0), 1);
      chk("st_rvalid1", 32'(RVALID1), 0);
      chk("st_rdata", 32'(RDATA), 32'h5A5A);
      chk("st_outstanding_zero", 32'(OUTSTANDING), 0);

      // ---- read routing ----
      cyc();
      REQ0 = 1; WE0 = 0; ADDR0 = 25'h100;
      REQ1 = 1; WE1 = 0; ADDR1 = 25'h200;
      settle();
      chk("rr_gnt0", 32'(GNT0), 1);
      chk("rr_gnt1_first", 32'(GNT1), 0);
      cyc(); REQ0 = 0; settle();
      chk("rr_gnt1_b2b", 32'(GNT1), 1);
      chk("rr_addr_a", 32'(SD_ADDR), 32'h100);
      cyc(); REQ1 = 0; settle();
      chk("rr_addr_b", 32'(SD_ADDR), 32'h200);
      chk("rr_rd_n_b", 32'(SD_RD_N), 0);
      chk("rr_outstanding2", 32'(OUTSTANDING), 2);
      SD_RDVALID = 1; SD_RDATA = 16'hAAAA;
      cyc(); SD_RDATA = 16'hBBBB; settle();
      chk("rr_rvalid0", 32'(RVALID0), 1);
      chk("rr_rvalid1_no", 32'(RVALID1), 0);
      chk("rr_rdata_a", 32'(RDATA), 32'hAAAA);
      cyc(); SD_RDVALID = 0; settle();
      chk("rr_rvalid1", 32'(RVALID1), 1);
      chk("rr_rvalid0_no", 32'(RVALID0), 0);
      chk("rr_rdata_b", 32'(RDATA), 32'hBBBB);
      chk("rr_outstanding0", 32'(OUTSTANDING), 0);

      // ---- outstanding limit ----
      cyc();
      REQ1 = 1; WE1 = 0; ADDR1 = 25'h300; g1 = 0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (GNT1) g1++;
         cyc();
         ADDR1 = 25'h300 + ADDR_W'(g1);
         if (g1 == 5) REQ1 = 0;
      end
      chk("lim_grants", 32'(g1), 4);
      chk("lim_outstanding4", 32'(OUTSTANDING), 4);
      REQ0 = 1; WE0 = 1; ADDR0 = 25'h400; WDATA0 = 16'h4444;
      settle();
      chk("lim_wr_gnt0", 32'(GNT0), 1);
      chk("lim_blocked_gnt1", 32'(GNT1), 0);
      cyc(); REQ0 = 0; settle();
      chk("lim_wr_n", 32'(SD_WR_N), 0);
      chk("lim_wr_addr", 32'(SD_ADDR), 32'h400);
      cyc(); settle();
      chk("lim_wr_n_release", 32'(SD_WR_N), 1);
      chk("lim_still_blocked", 32'(GNT1), 0);
      SD_RDVALID = 1; SD_RDATA = 16'h3000;
      cyc(); SD_RDVALID = 0; settle();
      chk("lim_fifth_gnt1", 32'(GNT1), 1);
      chk("lim_ret_rvalid1", 32'(RVALID1), 1);
      chk("lim_ret_rdata", 32'(RDATA), 32'h3000);
      chk("lim_outstanding3", 32'(OUTSTANDING), 3);
      cyc(); REQ1 = 0; settle();
      chk("lim_outstanding_back4", 32'(OUTSTANDING), 4);
      chk("lim_fifth_addr", 32'(SD_ADDR), 32'h304);
      for (int i = 0; i < 4; i++) begin
         SD_RDVALID = 1; SD_RDATA = 16'h3001 + DATA_W'(i);
         cyc(); SD_RDVALID = 0; settle();
         chk("lim_drain_rvalid1", 32'(RVALID1), 1);
         chk("lim_drain_rdata", 32'(RDATA), 32'h3001 + i);
      end
      cyc(); settle();
      chk("lim_outstanding_end", 32'(OUTSTANDING), 0);

      // ---- starvation: eight port-0 grants, then one port-1 grant ----
      REQ0 = 1; WE0 = 1; ADDR0 = 25'h500; WDATA0 = 16'h0500;
      REQ1 = 1; WE1 = 1; ADDR1 = 25'h600; WDATA1 = 16'h0600;
      for (int k = 0; k < 18; k++) begin
         settle();
         chk("starve_gnt0", 32'(GNT0), ((k % 9) == 8) ? 0 : 1);
         chk("starve_gnt1", 32'(GNT1), ((k % 9) == 8) ? 1 : 0);
         cyc();
      end
      REQ0 = 0; REQ1 = 0;
      cyc(); cyc();

      // ---- randomized traffic against the queue model ----
      model_out = 0;
      for (int c = 0; c < 700; c++) begin
         if (!REQ0 && c < 550 && $urandom_range(0, 2) == 0) begin
            REQ0 = 1; WE0 = 1'($urandom_range(0, 1));
            ADDR0 = ADDR_W'($urandom); WDATA0 = DATA_W'($urandom);
         end
         if (!REQ1 && c < 550 && $urandom_range(0, 2) == 0) begin
            REQ1 = 1; WE1 = 1'($urandom_range(0, 1));
            ADDR1 = ADDR_W'($urandom); WDATA1 = DATA_W'($urandom);
         end
         SD_WAITREQ = ($urandom_range(0, 3) == 0);
         ret = 0; p = 0; d = '0;
         if (rd_port_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            p = rd_port_q.pop_front();
            d = DATA_W'($urandom);
            ret = 1;
         end
         SD_RDVALID = ret; SD_RDATA = d;
         settle();

         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rnd_rvalid0", 32'(RVALID0), 32'(!e[DATA_W]));
            chk("rnd_rvalid1", 32'(RVALID1), 32'(e[DATA_W]));
            chk("rnd_rdata", 32'(RDATA), 32'(e[DATA_W-1:0]));
         end else begin
            chk("rnd_rvalid_idle", 32'({RVALID0, RVALID1}), 0);
         end
         chk("rnd_outstanding", 32'(OUTSTANDING), 32'(model_out));
         chk("rnd_enables_excl", 32'(SD_RD_N | SD_WR_N), 1);

         if ((!SD_RD_N || !SD_WR_N) && !SD_WAITREQ) begin
            chk("rnd_cmd_expected", 32'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0) begin
               c_exp = cmd_q.pop_front();
               chk("rnd_cmd_we", 32'(!SD_WR_N), 32'(c_exp[CW-2]));
               chk("rnd_cmd_addr", 32'(SD_ADDR), 32'(c_exp[ADDR_W+DATA_W-1:DATA_W]));
               if (c_exp[CW-2]) chk("rnd_cmd_wdata", 32'(SD_WDATA), 32'(c_exp[DATA_W-1:0]));
               else             rd_port_q.push_back(c_exp[CW-1]);
            end
         end

         chk("rnd_gnt_excl", 32'(GNT0 & GNT1), 0);
         if (GNT0) begin
            chk("rnd_gnt0_req", 32'(REQ0), 1);
            if (!WE0) begin
               chk("rnd_rd_limit0", 32'(model_out < MAX_RD), 1);
               model_out++;
            end
            cmd_q.push_back({1'b0, WE0, ADDR0, WDATA0});
         end
         if (GNT1) begin
            chk("rnd_gnt1_req", 32'(REQ1), 1);
            if (!WE1) begin
               chk("rnd_rd_limit1", 32'(model_out < MAX_RD), 1);
               model_out++;
            end
            cmd_q.push_back({1'b1, WE1, ADDR1, WDATA1});
         end
         if (ret) begin
            model_out--;
            exp_q.push_back({p, d});
         end
         g0s = GNT0; g1s = GNT1;
         cyc();
         if (g0s) REQ0 = 0;
         if (g1s) REQ1 = 0;
      end
      SD_RDVALID = 0; SD_WAITREQ = 0;
      settle();
      chk("rnd_drain_cmds", 32'(cmd_q.size()), 0);
      chk("rnd_drain_reads", 32'(rd_port_q.size()), 0);
      chk("rnd_drain_outstanding", 32'(OUTSTANDING), 0);
      chk("rnd_no_err", 32'(ERR), 0);
      chk("rnd_no_pending_req", 32'({REQ0, REQ1}), 0);
      cyc(); cyc();

      // ---- return with no pending tag ----
      settle();
      chk("err_before", 32'(ERR), 0);
      SD_RDVALID = 1; SD_RDATA = 16'hDEAD;
      cyc(); SD_RDVALID = 0; settle();
      chk("err_set", 32'(ERR), 1);
      chk("err_no_rvalid", 32'({RVALID0, RVALID1}), 0);
      chk("err_outstanding", 32'(OUTSTANDING), 0);
      cyc(); settle();
      chk("err_sticky", 32'(ERR), 1);

      // ---- asynchronous reset mid-command ----
      REQ0 = 1; WE0 = 1; ADDR0 = 25'h700; WDATA0 = 16'h0777; SD_WAITREQ = 1;
      settle();
      chk("ar_gnt0", 32'(GNT0), 1);
      cyc(); REQ0 = 0; settle();
      chk("ar_wr_n_low", 32'(SD_WR_N), 0);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("ar_wr_n", 32'(SD_WR_N), 1);
      chk("ar_rd_n", 32'(SD_RD_N), 1);
      chk("ar_err", 32'(ERR), 0);
      chk("ar_addr", 32'(SD_ADDR), 0);
      chk("ar_gnt", 32'({GNT0, GNT1}), 0);
      SD_WAITREQ = 0;
      @(negedge CLK);
      RESET_N = 1'b1;
      cyc(); settle();
      chk("ar_after_wr_n", 32'(SD_WR_N), 1);
      chk("ar_after_outstanding", 32'(OUTSTANDING), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
